// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request path: FSM state encoding,
// the "no floor" code and the floor-code width helper.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_CUR = 2'd1,
        PENDING = 2'd2
    } req_state_t;

    localparam int FLOOR_NONE = 0;

    // Minimum width that encodes floors 1..num_floors plus the 0 "none" code.
    function automatic int floor_width(input int num_floors);
        return $clog2(num_floors + 1);
    endfunction

endpackage

// File: rtl/elevator_floor_request_capture_if.sv
// Request channel from the floor-request capture block to the motion controller:
// pickup/destination floors qualified by a valid/ready pair.
interface elevator_floor_request_capture_if #(
    parameter int FLOOR_W = 5
);
    logic [FLOOR_W-1:0] current;
    logic [FLOOR_W-1:0] destination;
    logic               input_confirm;
    logic               req_ready;

    modport master (
        output current,
        output destination,
        output input_confirm,
        input  req_ready
    );

    modport slave (
        input  current,
        input  destination,
        input  input_confirm,
        output req_ready
    );
endinterface

// File: rtl/elevator_floor_request_capture_btn_debounce_edge.sv
// One push button: 2-flop synchroniser, debounce counter and a one-cycle
// pulse on each rising edge of the debounced level.
module btn_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                press_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/elevator_floor_request_capture.sv
// Captures a pickup then destination floor from debounced push buttons and
// holds the completed request on a valid/ready channel until accepted.
module elevator_floor_request_capture
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = 9,
    parameter int FLOOR_W         = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEST_TIMEOUT    = 1000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_FLOORS-1:0]                  push_btns,
    elevator_floor_request_capture_if.master       req,
    output logic                                   await_dest,
    output logic                                   entry_err
);
    localparam int TMR_W = (DEST_TIMEOUT > 1) ? $clog2(DEST_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEST_TIMEOUT - 1);

    if (FLOOR_W < floor_width(NUM_FLOORS)) begin : g_width_check
        $error("FLOOR_W too narrow to encode NUM_FLOORS");
    end

    logic [NUM_FLOORS-1:0] press_vec;

    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
        btn_debounce_edge #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .btn  (push_btns[gi]),
            .press(press_vec[gi])
        );
    end

    logic               any_press;
    logic               multi_press;
    logic               single_press;
    logic [FLOOR_W-1:0] press_floor;

    // OR of all floor codes; only meaningful when exactly one event is present.
    always_comb begin
        press_floor = FLOOR_W'(FLOOR_NONE);
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (press_vec[i]) begin
                press_floor = press_floor | FLOOR_W'(i + 1);
            end
        end
    end

    assign any_press    = |press_vec;
    assign multi_press  = |(press_vec & (press_vec - NUM_FLOORS'(1)));
    assign single_press = any_press && !multi_press;

    req_state_t         state_reg,   state_next;
    logic [FLOOR_W-1:0] current_reg, current_next;
    logic [FLOOR_W-1:0] dest_reg,    dest_next;
    logic               confirm_reg, confirm_next;
    logic               await_reg,   await_next;
    logic               err_reg,     err_next;
    logic [TMR_W-1:0]   timer_reg,   timer_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            current_reg <= FLOOR_W'(1);
            dest_reg    <= FLOOR_W'(1);
            confirm_reg <= 1'b0;
            await_reg   <= 1'b0;
            err_reg     <= 1'b0;
            timer_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            current_reg <= current_next;
            dest_reg    <= dest_next;
            confirm_reg <= confirm_next;
            await_reg   <= await_next;
            err_reg     <= err_next;
            timer_reg   <= timer_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        current_next = current_reg;
        dest_next    = dest_reg;
        confirm_next = confirm_reg;
        await_next   = await_reg;
        err_next     = 1'b0;
        timer_next   = timer_reg;
        case (state_reg)
            IDLE: begin
                if (multi_press) begin
                    err_next = 1'b1;
                end else if (single_press) begin
                    current_next = press_floor;
                    await_next   = 1'b1;
                    timer_next   = '0;
                    state_next   = GOT_CUR;
                end
            end
            GOT_CUR: begin
                timer_next = timer_reg + TMR_W'(1);
                if (single_press && press_floor != current_reg) begin
                    dest_next    = press_floor;
                    await_next   = 1'b0;
                    confirm_next = 1'b1;
                    state_next   = PENDING;
                end else begin
                    // Remaining presses are either ambiguous or repeat the pickup floor.
                    if (any_press) begin
                        err_next = 1'b1;
                    end
                    if (timer_reg == TMR_LAST) begin
                        err_next   = 1'b1;
                        await_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            PENDING: begin
                if (req.req_ready) begin
                    confirm_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req.current       = current_reg;
    assign req.destination   = dest_reg;
    assign req.input_confirm = confirm_reg;
    assign await_dest        = await_reg;
    assign entry_err         = err_reg;

endmodule

// File: tb/tb_elevator_floor_request_capture.sv
// Directed bench: table of button/handshake vectors with hand-computed
// expectations, plus hand-written bounce, latency/timeout and reset sequences.
module tb_elevator_floor_request_capture;

    localparam int NUM_FLOORS = 9;
    localparam int FLOOR_W    = 5;
    localparam int DEB        = 4;
    localparam int TMO        = 1000;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_FLOORS-1:0] push_btns = '0;
    logic                  await_dest;
    logic                  entry_err;

    elevator_floor_request_capture_if #(.FLOOR_W(FLOOR_W)) req_if ();

    elevator_floor_request_capture #(
        .NUM_FLOORS     (NUM_FLOORS),
        .FLOOR_W        (FLOOR_W),
        .DEBOUNCE_CYCLES(DEB),
        .DEST_TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_btns (push_btns),
        .req       (req_if),
        .await_dest(await_dest),
        .entry_err (entry_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    // Counts cycles in which entry_err was high; a stuck pulse shows as >1.
    always @(posedge clk) begin
        if (entry_err) err_seen <= err_seen + 1;
    end

    typedef struct {
        string                 name;
        logic [NUM_FLOORS-1:0] mask;
        int                    hold;
        int                    gap;
        bit                    rdy;
        int                    cur;
        int                    dst;
        int                    conf;
        int                    aw;
        int                    errs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [NUM_FLOORS-1:0] mask,
                                input int hold, input int gap, input bit rdy,
                                input int cur, input int dst, input int conf,
                                input int aw, input int errs);
        vec_t v;
        v.name = name; v.mask = mask; v.hold = hold; v.gap = gap; v.rdy = rdy;
        v.cur = cur; v.dst = dst; v.conf = conf; v.aw = aw; v.errs = errs;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string nm, input int cur, input int dst,
                                 input int conf, input int aw);
        check({nm, ".current"},       int'(req_if.current),       cur);
        check({nm, ".destination"},   int'(req_if.destination),   dst);
        check({nm, ".input_confirm"}, int'(req_if.input_confirm), conf);
        check({nm, ".await_dest"},    int'(await_dest),           aw);
    endtask

    task automatic run_vec(input vec_t v);
        int base;
        base = err_seen;
        req_if.req_ready = v.rdy;
        push_btns = v.mask;
        repeat (v.hold) @(negedge clk);
        push_btns = '0;
        repeat (v.gap) @(negedge clk);
        req_if.req_ready = 1'b0;
        @(negedge clk);
        check_outputs(v.name, v.cur, v.dst, v.conf, v.aw);
        check({v.name, ".err_pulses"}, err_seen - base, v.errs);
        $display("vec %s: btns=%h cur=%0d dst=%0d conf=%0b await=%0b errs=%0d",
                 v.name, v.mask, req_if.current, req_if.destination,
                 req_if.input_confirm, await_dest, err_seen - base);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        req_if.req_ready = 1'b0;

        //            name          mask       hold gap rdy cur dst conf aw err
        vecs.push_back(mk("pick3",     9'h004, 10, 10, 0, 3, 1, 0, 1, 0));
        vecs.push_back(mk("dest7",     9'h040, 10, 10, 0, 3, 7, 1, 0, 0));
        vecs.push_back(mk("hold",      9'h000,  5,  5, 0, 3, 7, 1, 0, 0));
        vecs.push_back(mk("pend_ign",  9'h001, 10, 10, 0, 3, 7, 1, 0, 0));
        vecs.push_back(mk("accept1",   9'h000,  1,  2, 1, 3, 7, 0, 0, 0));
        vecs.push_back(mk("rdy_idle",  9'h000,  3,  3, 1, 3, 7, 0, 0, 0));
        vecs.push_back(mk("dual34",    9'h018, 10, 10, 0, 3, 7, 0, 0, 1));
        vecs.push_back(mk("pick5",     9'h010, 10, 10, 0, 5, 7, 0, 1, 0));
        vecs.push_back(mk("same5",     9'h010, 10, 10, 0, 5, 7, 0, 1, 1));
        vecs.push_back(mk("dest2",     9'h002, 10, 10, 0, 5, 2, 1, 0, 0));
        vecs.push_back(mk("accept2",   9'h000,  1,  2, 1, 5, 2, 0, 0, 0));
        vecs.push_back(mk("all_btn",   9'h1ff, 10, 10, 0, 5, 2, 0, 0, 1));
        vecs.push_back(mk("held6",     9'h020, 40, 10, 0, 6, 2, 0, 1, 0));
        vecs.push_back(mk("again6",    9'h020, 10, 10, 0, 6, 2, 0, 1, 1));
        vecs.push_back(mk("dest3",     9'h004, 10, 10, 0, 6, 3, 1, 0, 0));
        vecs.push_back(mk("accept3",   9'h000,  1,  2, 1, 6, 3, 0, 0, 0));

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset", 1, 1, 0, 0);
        check("reset.entry_err", int'(entry_err), 0);
        $display("reset: cur=%0d dst=%0d conf=%0b await=%0b",
                 req_if.current, req_if.destination, req_if.input_confirm, await_dest);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Bounce 1-0-1-0 on floor 1, then stable high: exactly one event.
        base = err_seen;
        push_btns = 9'h001; @(negedge clk);
        push_btns = 9'h000; @(negedge clk);
        push_btns = 9'h001; @(negedge clk);
        push_btns = 9'h000; @(negedge clk);
        push_btns = 9'h001; repeat (10) @(negedge clk);
        push_btns = 9'h000; repeat (10) @(negedge clk);
        check_outputs("bounce", 1, 3, 0, 1);
        check("bounce.err_pulses", err_seen - base, 0);
        $display("bounce: cur=%0d await=%0b errs=%0d", req_if.current, await_dest, err_seen - base);
        run_vec(mk("dest9",   9'h100, 10, 10, 0, 1, 9, 1, 0, 0));
        run_vec(mk("accept4", 9'h000,  1,  2, 1, 1, 9, 0, 0, 0));

        // Latency from raw rise to await_dest, then destination timeout.
        push_btns = 9'h008;
        repeat (2 + DEB) @(negedge clk);
        check("lat.await_before", int'(await_dest), 0);
        @(negedge clk);
        check("lat.await_after", int'(await_dest), 1);
        check("lat.current", int'(req_if.current), 4);
        push_btns = '0;
        repeat (TMO - 1) @(negedge clk);
        check("tmo.err_before", int'(entry_err), 0);
        check("tmo.await_before", int'(await_dest), 1);
        @(negedge clk);
        check("tmo.err_pulse", int'(entry_err), 1);
        check_outputs("tmo", 4, 9, 0, 0);
        @(negedge clk);
        check("tmo.err_after", int'(entry_err), 0);
        $display("timeout: cur=%0d await=%0b conf=%0b", req_if.current, await_dest, req_if.input_confirm);

        // Reset while a request is pending.
        run_vec(mk("pick2",  9'h002, 10, 10, 0, 2, 9, 0, 1, 0));
        run_vec(mk("dest7b", 9'h040, 10, 10, 0, 2, 7, 1, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outputs("rst_pend", 1, 1, 0, 0);
        check("rst_pend.entry_err", int'(entry_err), 0);
        $display("rst_pend: cur=%0d dst=%0d conf=%0b", req_if.current, req_if.destination, req_if.input_confirm);
        run_vec(mk("pick8", 9'h080, 10, 10, 0, 8, 1, 0, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_floor_request_capture.md
Name: elevator_floor_request_capture

Overview:
Parametrised successor to the single-shot push-button decoder in the elevator path. It captures a two-press request (pickup floor, then destination floor) from NUM_FLOORS raw push buttons. Buttons are debounced and rising-edge detected, and ambiguous or invalid presses are rejected. The completed request is presented to the elevator motion controller over a valid/ready handshake, and the block holds it until the request is accepted.

Parameters:
NUM_FLOORS, 9, number of floors/buttons; floors encoded 1..NUM_FLOORS, 0 = none
FLOOR_W, 5, width of floor code; must satisfy 2**FLOOR_W > NUM_FLOORS
DEBOUNCE_CYCLES, 4, consecutive stable samples required before a button level is accepted (>=1)
DEST_TIMEOUT, 1000, cycles allowed between pickup press and destination press (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous active-high reset
push_btns  in  NUM_FLOORS  raw asynchronous buttons, bit i = floor i+1
current  out  FLOOR_W  captured pickup floor
destination  out  FLOOR_W  captured destination floor
input_confirm  out  1  request valid; high while a complete request is held
req_ready  in  1  motion controller accepts the request when high with input_confirm
await_dest  out  1  high while waiting for the destination press
entry_err  out  1  one-cycle pulse when a press is rejected or a timeout occurs

Behaviour:
- Reset: all outputs are registered. Reset values: current=1, destination=1, input_confirm=0, await_dest=0, entry_err=0. The FSM enters IDLE, and debouncers clear to stable-low with counters at 0.
- Input path: each button passes through a 2-flop synchroniser, then a debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive samples differ from it. A press event is a one-cycle rising edge of the debounced level.
- Latency: raw rise to press event = 2 + DEBOUNCE_CYCLES cycles. Press event to FSM output update = 1 cycle.
- Decode: in a cycle with exactly one press event, the event maps to floor index+1.
  - Zero events: no action.
  - Two or more events in the same cycle: all ignored, entry_err pulses, state unchanged.
- FSM states and transitions:
  - IDLE: on a valid press, current := floor, await_dest := 1, timer := 0, go to GOT_CUR.
  - GOT_CUR:
    - Timer increments each cycle.
    - Valid press with floor != current: destination := floor, await_dest := 0, input_confirm := 1, go to PENDING.
    - Press of floor == current: rejected, entry_err pulses, stay in GOT_CUR, timer not reset.
    - Timer reaching DEST_TIMEOUT-1 with no valid press: entry_err pulses, await_dest := 0, go to IDLE. current keeps its value.
  - PENDING:
    - input_confirm is held high; current and destination are held stable.
    - Presses are ignored, with no error pulse.
    - When req_ready=1, the request is accepted: input_confirm := 0 the next cycle, go to IDLE.
- Handshake: transfer occurs when input_confirm && req_ready on the same edge. req_ready while input_confirm=0 has no effect. input_confirm never drops without a transfer, except on rst.
- Simultaneous events: if a timeout and a valid destination press land on the same cycle, the press wins.
- Held button: a continuously held button produces one event only. A new event requires a debounced low then high.
- Reset mid-operation: a request pending or partially entered is discarded; outputs return to reset values the next cycle.
- Width rule: decoded floor is zero-extended to FLOOR_W. Elaboration fails if 2**FLOOR_W <= NUM_FLOORS.

Decomposition:
- Shared package elevator_pkg holds:
  - the FSM state encoding (IDLE, GOT_CUR, PENDING)
  - a FLOOR_NONE=0 constant
  - a floor-width helper function, also used by the motion controller
- One sub-module, btn_debounce_edge: per-button synchroniser, debounce counter and rising-edge output, parametrised by DEBOUNCE_CYCLES. It is instantiated NUM_FLOORS times via generate.
- Timer and decode stay in the top module.

Test Plan:
1. Reset, then press bit 2 and later bit 6, each held 10 cycles; req_ready=0 -> current=3, destination=7, input_confirm high and holding. Assert req_ready for 1 cycle -> input_confirm low the next cycle, FSM in IDLE.
2. Raw bounce 1-0-1-0 on bit 0 with DEBOUNCE_CYCLES=4, then stable high -> exactly one press event; await_dest=1, current=1.
3. Bits 3 and 4 rise on the same cycle in IDLE -> entry_err one-cycle pulse, await_dest stays 0, current unchanged.
4. Pickup floor 5, then press floor 5 again -> entry_err pulse, still in GOT_CUR. Then press floor 2 -> destination=2, input_confirm=1.
5. Pickup floor 4 with no further press for DEST_TIMEOUT cycles -> entry_err pulse exactly at timeout, await_dest=0, input_confirm stays 0.
6. rst asserted during PENDING with req_ready=0 -> next cycle input_confirm=0, current=1, destination=1. A later press of floor 8 is accepted as the pickup floor.
